disp_mode_ctrl: RTL and testbench



---
 rtl/disp_pkg.sv | 33 +++
 rtl/disp_mode_ctrl_if.sv | 25 ++
 rtl/ms_down_timer.sv | 27 ++
 rtl/disp_mode_ctrl.sv | 153 +++++++++++++++
 tb/tb_disp_mode_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the front-panel display mode scheduler.
package disp_pkg;

  localparam int DISP_W = 12;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    EDIT = 2'd1,
    PID  = 2'd2
  } state_t;

  localparam logic [1:0] PG_NONE = 2'd0;
  localparam logic [1:0] PG_P    = 2'd1;
  localparam logic [1:0] PG_I    = 2'd2;
  localparam logic [1:0] PG_D    = 2'd3;

  localparam logic [2:0] HUND = 3'd2;
  localparam logic [2:0] TENS = 3'd1;
  localparam logic [2:0] ONES = 3'd0;

  function automatic logic [DISP_W-1:0] digits_to_val(logic [3:0] h, logic [3:0] t, logic [3:0] o);
    return DISP_W'(h) * DISP_W'(100) + DISP_W'(t) * DISP_W'(10) + DISP_W'(o);
  endfunction

  function automatic logic [3:0] dig_inc(logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] dig_dec(logic [3:0] d);
    return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
  endfunction

endpackage

// File: rtl/disp_mode_ctrl_if.sv
// Key inputs, temperature and display/alarm outputs of the display mode scheduler.
interface disp_mode_ctrl_if;
  logic                        key_set;
  logic                        key_sel;
  logic                        key_up;
  logic                        key_down;
  logic                        key_pid;
  logic [disp_pkg::DISP_W-1:0] temp_data;
  logic                        show_flag;
  logic [2:0]                  flash_flag;
  logic [1:0]                  pid_show;
  logic [disp_pkg::DISP_W-1:0] data_warn;
  logic [disp_pkg::DISP_W-1:0] warn_thr;
  logic                        alarm;

  modport master (
    output key_set, key_sel, key_up, key_down, key_pid, temp_data,
    input  show_flag, flash_flag, pid_show, data_warn, warn_thr, alarm
  );

  modport slave (
    input  key_set, key_sel, key_up, key_down, key_pid, temp_data,
    output show_flag, flash_flag, pid_show, data_warn, warn_thr, alarm
  );
endinterface

// File: rtl/ms_down_timer.sv
// Loadable millisecond down-counter; expire_o is high while enabled and at zero.
module ms_down_timer #(
  parameter int W = 16
) (
  input  logic         clk_1ms,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_1ms) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/disp_mode_ctrl.sv
// Display mode scheduler: RUN / threshold EDIT / timed PID pages, plus hysteretic alarm.
// Optional edit idle timeout is built when EDIT_TIMEOUT_EN is defined.
//
//   state | meaning
//   RUN   | live temperature shown, waits for key_set / key_pid
//   EDIT  | working threshold digits edited, selected digit flashing
//   PID   | P, I, D pages shown in turn, each held PID_HOLD_MS ticks
module disp_mode_ctrl
  import disp_pkg::*;
#(
  parameter int PID_HOLD_MS     = 1000,
  parameter int EDIT_TIMEOUT_MS = 5000,
  parameter int WARN_RESET      = 50,
  parameter int HYST            = 2
) (
  input  logic            clk_1ms,
  input  logic            rst,
  disp_mode_ctrl_if.slave bus
);

  // Both timers share one width, sized for the longer interval.
  localparam int TMR_MAX = (EDIT_TIMEOUT_MS > PID_HOLD_MS) ? EDIT_TIMEOUT_MS : PID_HOLD_MS;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [2:0][3:0] RST_DIG = {4'((WARN_RESET / 100) % 10),
                                         4'((WARN_RESET / 10) % 10),
                                         4'(WARN_RESET % 10)};
  localparam logic [DISP_W-1:0] HYST_V = DISP_W'(HYST);

  state_t            state_q;
  logic              show_q;
  logic [2:0]        flash_q;
  logic [1:0]        pid_q;
  logic              alarm_q, alarm_d;
  logic [2:0][3:0]   dig_q;
  logic [2:0][3:0]   cdig_q;
  logic [DISP_W-1:0] warn_thr_q;
  logic [DISP_W-1:0] data_warn;
  logic [DISP_W-1:0] thr_lo;
  logic [1:0]        sel;
  logic              pid_step, pid_load, pid_exp;
  logic              edit_exp;

  assign data_warn = digits_to_val(dig_q[2], dig_q[1], dig_q[0]);
  assign sel       = flash_q[1:0];

  assign pid_step = (state_q == PID) && (bus.key_pid || pid_exp);
  assign pid_load = ((state_q == RUN) && !bus.key_set && bus.key_pid) || pid_step;

  ms_down_timer #(.W(TMR_W)) u_pid_tmr (
    .clk_1ms    (clk_1ms),
    .rst        (rst),
    .load_i     (pid_load),
    .load_val_i (TMR_W'(PID_HOLD_MS - 1)),
    .en_i       (state_q == PID),
    .expire_o   (pid_exp)
  );

`ifdef EDIT_TIMEOUT_EN
  logic edit_load;
  assign edit_load = ((state_q == RUN) && bus.key_set) ||
                     ((state_q == EDIT) && (bus.key_set || bus.key_sel || bus.key_up || bus.key_down));

  ms_down_timer #(.W(TMR_W)) u_edit_tmr (
    .clk_1ms    (clk_1ms),
    .rst        (rst),
    .load_i     (edit_load),
    .load_val_i (TMR_W'(EDIT_TIMEOUT_MS - 1)),
    .en_i       (state_q == EDIT),
    .expire_o   (edit_exp)
  );
`else
  assign edit_exp = 1'b0;
`endif

  // Release point saturates at zero so small thresholds never wrap.
  always_comb begin
    thr_lo  = (warn_thr_q > HYST_V) ? warn_thr_q - HYST_V : '0;
    alarm_d = alarm_q;
    if (bus.temp_data >= warn_thr_q) begin
      alarm_d = 1'b1;
    end else if (bus.temp_data < thr_lo) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk_1ms) begin
    if (rst) begin
      state_q    <= RUN;
      show_q     <= 1'b0;
      flash_q    <= ONES;
      pid_q      <= PG_NONE;
      alarm_q    <= 1'b0;
      dig_q      <= RST_DIG;
      cdig_q     <= RST_DIG;
      warn_thr_q <= DISP_W'(WARN_RESET);
    end else begin
      alarm_q <= alarm_d;
      case (state_q)
        RUN: begin
          if (bus.key_set) begin
            dig_q   <= cdig_q;
            flash_q <= HUND;
            show_q  <= 1'b1;
            state_q <= EDIT;
          end else if (bus.key_pid) begin
            pid_q   <= PG_P;
            state_q <= PID;
          end
        end
        EDIT: begin
          if (bus.key_set) begin
            cdig_q     <= dig_q;
            warn_thr_q <= data_warn;
            show_q     <= 1'b0;
            flash_q    <= ONES;
            state_q    <= RUN;
          end else if (bus.key_sel) begin
            flash_q <= (flash_q == ONES) ? HUND : flash_q - 3'd1;
          end else if (bus.key_up) begin
            dig_q[sel] <= dig_inc(dig_q[sel]);
          end else if (bus.key_down) begin
            dig_q[sel] <= dig_dec(dig_q[sel]);
          end else if (edit_exp) begin
            dig_q   <= cdig_q;
            show_q  <= 1'b0;
            flash_q <= ONES;
            state_q <= RUN;
          end
        end
        PID: begin
          if (pid_step) begin
            if (pid_q == PG_D) begin
              pid_q   <= PG_NONE;
              state_q <= RUN;
            end else begin
              pid_q <= pid_q + 2'd1;
            end
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.show_flag  = show_q;
  assign bus.flash_flag = flash_q;
  assign bus.pid_show   = pid_q;
  assign bus.data_warn  = data_warn;
  assign bus.warn_thr   = warn_thr_q;
  assign bus.alarm      = alarm_q;

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Bench for disp_mode_ctrl: vector table plus hand sequences, checked through a scoreboard queue.
// EDIT_TIMEOUT_EN selects the idle-timeout expectations.
module tb_disp_mode_ctrl;

  localparam logic [4:0] KS = 5'b10000;
  localparam logic [4:0] KL = 5'b01000;
  localparam logic [4:0] KU = 5'b00100;
  localparam logic [4:0] KD = 5'b00010;
  localparam logic [4:0] KP = 5'b00001;
  localparam logic [4:0] K0 = 5'b00000;

  typedef struct {
    logic        rst;
    logic [4:0]  keys;
    logic [11:0] temp;
    logic        show;
    logic [2:0]  flash;
    logic [1:0]  pid;
    logic [11:0] dw;
    logic [11:0] wt;
    logic        al;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_vec   = 0;
  vec_t tbl[$];
  vec_t sb[$];
  vec_t exp_v;

  disp_mode_ctrl_if bus ();

  disp_mode_ctrl #(
    .PID_HOLD_MS     (4),
    .EDIT_TIMEOUT_MS (8),
    .WARN_RESET      (50),
    .HYST            (2)
  ) dut (
    .clk_1ms (clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [4:0] k, int t, logic s, int f, int p, int dw, int wt, logic al);
    vec_t v;
    v.rst = r; v.keys = k; v.temp = 12'(t);
    v.show = s; v.flash = 3'(f); v.pid = 2'(p);
    v.dw = 12'(dw); v.wt = 12'(wt); v.al = al;
    return v;
  endfunction

  task automatic add(logic r, logic [4:0] k, int t, logic s, int f, int p, int dw, int wt, logic al);
    tbl.push_back(mk(r, k, t, s, f, p, dw, wt, al));
  endtask

  task automatic drive(vec_t v);
    @(negedge clk);
    rst          = v.rst;
    bus.key_set  = v.keys[4];
    bus.key_sel  = v.keys[3];
    bus.key_up   = v.keys[2];
    bus.key_down = v.keys[1];
    bus.key_pid  = v.keys[0];
    bus.temp_data = v.temp;
    sb.push_back(v);
  endtask

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got %0d, expected %0d", nm, n_vec, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_v = sb.pop_front();
      chk("show_flag",  int'(bus.show_flag),  int'(exp_v.show));
      chk("flash_flag", int'(bus.flash_flag), int'(exp_v.flash));
      chk("pid_show",   int'(bus.pid_show),   int'(exp_v.pid));
      chk("data_warn",  int'(bus.data_warn),  int'(exp_v.dw));
      chk("warn_thr",   int'(bus.warn_thr),   int'(exp_v.wt));
      chk("alarm",      int'(bus.alarm),      int'(exp_v.al));
      n_vec++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d vectors checked", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_set = 1'b0; bus.key_sel = 1'b0; bus.key_up = 1'b0;
    bus.key_down = 1'b0; bus.key_pid = 1'b0; bus.temp_data = '0;

    // reset and alarm hysteresis around 50
    add(1, K0, 0,   0, 0, 0, 50, 50, 0);
    add(1, K0, 0,   0, 0, 0, 50, 50, 0);
    add(0, K0, 49,  0, 0, 0, 50, 50, 0);
    add(0, K0, 50,  0, 0, 0, 50, 50, 1);
    add(0, K0, 48,  0, 0, 0, 50, 50, 1);
    add(0, K0, 47,  0, 0, 0, 50, 50, 0);
    // edit to 340
    add(0, KS, 0,   1, 2, 0, 50, 50, 0);
    for (int i = 1; i <= 3; i++) add(0, KU, 0, 1, 2, 0, 50 + 100 * i, 50, 0);
    add(0, KL, 0,   1, 1, 0, 350, 50, 0);
    add(0, KD, 0,   1, 1, 0, 340, 50, 0);
    add(0, KS, 0,   0, 0, 0, 340, 340, 0);
    add(0, K0, 340, 0, 0, 0, 340, 340, 1);
    add(0, K0, 338, 0, 0, 0, 340, 340, 1);
    add(0, K0, 337, 0, 0, 0, 340, 340, 0);
    // ones wrap with no carry, select wrap, set beats up
    add(0, KS, 0,   1, 2, 0, 340, 340, 0);
    add(0, KL, 0,   1, 1, 0, 340, 340, 0);
    add(0, KL, 0,   1, 0, 0, 340, 340, 0);
    for (int i = 1; i <= 10; i++) add(0, KU, 0, 1, 0, 0, 340 + (i % 10), 340, 0);
    add(0, KL, 0,   1, 2, 0, 340, 340, 0);
    add(0, KD, 0,   1, 2, 0, 240, 340, 0);
    add(0, KS | KU, 0, 0, 0, 0, 240, 240, 0);
    add(0, KD | KL, 0, 0, 0, 0, 240, 240, 0);
    // ones borrow-free wrap 0 -> 9
    add(0, KS, 0,   1, 2, 0, 240, 240, 0);
    add(0, KL, 0,   1, 1, 0, 240, 240, 0);
    add(0, KL, 0,   1, 0, 0, 240, 240, 0);
    add(0, KD, 0,   1, 0, 0, 249, 240, 0);
    add(0, KS, 0,   0, 0, 0, 249, 249, 0);
    // walk down to threshold 1, then saturated release point
    add(0, KS, 0,   1, 2, 0, 249, 249, 0);
    add(0, KD, 0,   1, 2, 0, 149, 249, 0);
    add(0, KD, 0,   1, 2, 0, 49, 249, 0);
    add(0, KL, 0,   1, 1, 0, 49, 249, 0);
    for (int i = 1; i <= 4; i++) add(0, KD, 0, 1, 1, 0, 49 - 10 * i, 249, 0);
    add(0, KL, 0,   1, 0, 0, 9, 249, 0);
    for (int i = 1; i <= 8; i++) add(0, KD, 0, 1, 0, 0, 9 - i, 249, 0);
    add(0, KS, 0,   0, 0, 0, 1, 1, 0);
    add(0, K0, 1,   0, 0, 0, 1, 1, 1);
    add(0, K0, 0,   0, 0, 0, 1, 1, 1);
    add(0, K0, 0,   0, 0, 0, 1, 1, 1);

    foreach (tbl[i]) drive(tbl[i]);

    // full PID sequence with 4-tick pages
    begin
      int pages[12] = '{1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
      drive(mk(0, KP, 0, 0, 0, 1, 1, 1, 1));
      for (int i = 0; i < 12; i++) drive(mk(0, K0, 0, 0, 0, pages[i], 1, 1, 1));
      drive(mk(0, K0, 0, 0, 0, 0, 1, 1, 1));
    end

    // key_pid mid-page advances immediately; edit keys ignored; exit from page 3
    drive(mk(0, KP, 0, 0, 0, 1, 1, 1, 1));
    drive(mk(0, K0, 0, 0, 0, 1, 1, 1, 1));
    drive(mk(0, KP, 0, 0, 0, 2, 1, 1, 1));
    for (int i = 0; i < 3; i++) drive(mk(0, K0, 0, 0, 0, 2, 1, 1, 1));
    drive(mk(0, K0, 0, 0, 0, 3, 1, 1, 1));
    drive(mk(0, KS | KL | KU, 0, 0, 0, 3, 1, 1, 1));
    drive(mk(0, KD, 0, 0, 0, 3, 1, 1, 1));
    drive(mk(0, KP, 0, 0, 0, 0, 1, 1, 1));
    drive(mk(0, K0, 0, 0, 0, 0, 1, 1, 1));

    // reset mid-edit discards the working value
    drive(mk(0, KS, 0, 1, 2, 0, 1, 1, 1));
    drive(mk(0, KU, 0, 1, 2, 0, 101, 1, 1));
    drive(mk(1, K0, 0, 0, 0, 0, 50, 50, 0));
    drive(mk(0, K0, 0, 0, 0, 0, 50, 50, 0));

    // reset mid-PID
    drive(mk(0, KP, 0, 0, 0, 1, 50, 50, 0));
    drive(mk(0, K0, 0, 0, 0, 1, 50, 50, 0));
    drive(mk(1, K0, 0, 0, 0, 0, 50, 50, 0));
    drive(mk(0, K0, 0, 0, 0, 0, 50, 50, 0));

    // idle in EDIT
    drive(mk(0, KS, 0, 1, 2, 0, 50, 50, 0));
    drive(mk(0, KU, 0, 1, 2, 0, 150, 50, 0));
`ifdef EDIT_TIMEOUT_EN
    for (int i = 0; i < 7; i++) drive(mk(0, K0, 0, 1, 2, 0, 150, 50, 0));
    drive(mk(0, K0, 0, 0, 0, 0, 50, 50, 0));
    // key on the expiry cycle keeps EDIT and restarts the idle count
    drive(mk(0, KS, 0, 1, 2, 0, 50, 50, 0));
    drive(mk(0, KU, 0, 1, 2, 0, 150, 50, 0));
    for (int i = 0; i < 7; i++) drive(mk(0, K0, 0, 1, 2, 0, 150, 50, 0));
    drive(mk(0, KU, 0, 1, 2, 0, 250, 50, 0));
    for (int i = 0; i < 7; i++) drive(mk(0, K0, 0, 1, 2, 0, 250, 50, 0));
    drive(mk(0, K0, 0, 0, 0, 0, 50, 50, 0));
`else
    for (int i = 0; i < 8; i++) drive(mk(0, K0, 0, 1, 2, 0, 150, 50, 0));
    drive(mk(0, KS, 0, 0, 0, 0, 150, 150, 0));
`endif
    drive(mk(0, K0, 0, 0, 0, 0, bus.data_warn == 12'd150 ? 150 : 50, 0, 0));
    sb.pop_back();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
